// File: rtl/garage_door_ctrl_gen2.sv
//------------------------------------------------------------------------------
// garage_door_ctrl_gen2 : edge-triggered multi-remote garage door controller
//   with obstruction reversal, travel-timeout fault and sensor-conflict fault.
// Optional autoclose of an idle open door: define GARAGE_AUTOCLOSE_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1us/1ns

module garage_door_ctrl_gen2 #(
   parameter int NUM_REMOTES      = 2,
   parameter int TRAVEL_TIMEOUT   = 1000,
   parameter int REV_DWELL        = 4,
   parameter int AUTOCLOSE_CYCLES = 5000
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NUM_REMOTES-1:0] Activate,
   input  logic                   UP_MAX,
   input  logic                   DOWN_MAX,
   input  logic                   OBSTRUCT,
   input  logic                   FAULT_CLR,
   output logic                   UP_M,
   output logic                   DOWN_M,
   output logic                   FAULT
);

   localparam int BASE_MAX = (TRAVEL_TIMEOUT > REV_DWELL) ? TRAVEL_TIMEOUT : REV_DWELL;
`ifdef GARAGE_AUTOCLOSE_EN
   localparam int TMR_MAX  = (AUTOCLOSE_CYCLES > BASE_MAX) ? AUTOCLOSE_CYCLES : BASE_MAX;
`else
   localparam int TMR_MAX  = BASE_MAX;
`endif
   localparam int TW = $clog2(TMR_MAX + 1);

   // Compare against N-1: the timer holds the number of cycles already
   // completed in the state, so the Nth cycle ends at this edge.
   localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TIMEOUT - 1);
   localparam logic [TW-1:0] DWELL_LAST  = TW'(REV_DWELL - 1);
   localparam logic [TW-1:0] TMR_SAT     = {TW{1'b1}};
`ifdef GARAGE_AUTOCLOSE_EN
   localparam logic [TW-1:0] AUTO_LAST   = TW'(AUTOCLOSE_CYCLES - 1);
`endif

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   if (NUM_REMOTES < 1 || TRAVEL_TIMEOUT < 1 || REV_DWELL < 1 || AUTOCLOSE_CYCLES < 1)
   begin : g_bad_params
      $error("garage_door_ctrl_gen2: all parameters must be >= 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_MV_UP    = 3'd1,
      ST_MV_DN    = 3'd2,
      ST_REV_WAIT = 3'd3,
      ST_FAULT    = 3'd4
   } state_t;

   state_t                 state;
   state_t                 next_state;
   logic [NUM_REMOTES-1:0] act_q;
   logic [TW-1:0]          timer;
   logic                   last_dir;
   logic                   act_pulse;
   logic                   conflict;
   logic                   door_open;

   assign act_pulse = |(Activate & ~act_q);
   assign conflict  = UP_MAX & DOWN_MAX;
   assign door_open = UP_MAX & ~DOWN_MAX;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
         act_q <= '0;
      end else begin
         state <= next_state;
         act_q <= Activate;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (conflict) begin
               next_state = ST_FAULT;
            end else if (act_pulse) begin
               if (DOWN_MAX) begin
                  next_state = ST_MV_UP;
               end else if (UP_MAX) begin
                  if (!OBSTRUCT) begin
                     next_state = ST_MV_DN;
                  end
               end else begin
                  next_state = (last_dir == DIR_UP) ? ST_MV_DN : ST_MV_UP;
               end
`ifdef GARAGE_AUTOCLOSE_EN
            end else if (door_open && !OBSTRUCT && timer == AUTO_LAST) begin
               next_state = ST_MV_DN;
`endif
            end
         end
         ST_MV_UP: begin
            if (conflict) begin
               next_state = ST_FAULT;
            end else if (UP_MAX || act_pulse) begin
               next_state = ST_IDLE;
            end else if (timer == TRAVEL_LAST) begin
               next_state = ST_FAULT;
            end
         end
         ST_MV_DN: begin
            if (conflict) begin
               next_state = ST_FAULT;
            end else if (DOWN_MAX) begin
               next_state = ST_IDLE;
            end else if (OBSTRUCT) begin
               next_state = ST_REV_WAIT;
            end else if (act_pulse) begin
               next_state = ST_IDLE;
            end else if (timer == TRAVEL_LAST) begin
               next_state = ST_FAULT;
            end
         end
         ST_REV_WAIT: begin
            if (conflict) begin
               next_state = ST_FAULT;
            end else if (act_pulse) begin
               next_state = ST_IDLE;
            end else if (timer == DWELL_LAST) begin
               next_state = ST_MV_UP;
            end
         end
         ST_FAULT: begin
            if (FAULT_CLR) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         timer <= '0;
      end else if (next_state != state) begin
         timer <= '0;
`ifdef GARAGE_AUTOCLOSE_EN
      end else if (state == ST_IDLE && (!door_open || OBSTRUCT || act_pulse)) begin
         timer <= '0;
`endif
      end else if (timer != TMR_SAT) begin
         timer <= timer + TW'(1);
      end
   end

   // An aborted reversal counts as a downward move, so the next command lifts.
   always_ff @(posedge CLK) begin
      if (RST) begin
         last_dir <= DIR_DOWN;
      end else if (next_state == ST_MV_UP && state != ST_MV_UP) begin
         last_dir <= DIR_UP;
      end else if (next_state == ST_MV_DN && state != ST_MV_DN) begin
         last_dir <= DIR_DOWN;
      end else if (state == ST_REV_WAIT && next_state == ST_IDLE) begin
         last_dir <= DIR_DOWN;
      end
   end

   assign UP_M   = (state == ST_MV_UP);
   assign DOWN_M = (state == ST_MV_DN);
   assign FAULT  = (state == ST_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_garage_door_ctrl_gen2.sv
//------------------------------------------------------------------------------
// tb_garage_door_ctrl_gen2 : directed plus randomized bench for the default
//   build, compared every cycle against a motion-level door model.
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1us/1ns

module tb_garage_door_ctrl_gen2;

   localparam int NR  = 2;
   localparam int TMO = 20;
   localparam int DWL = 3;
   localparam int ACL = 10;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [NR-1:0] Activate = '0;
   logic          UP_MAX = 1'b0;
   logic          DOWN_MAX = 1'b0;
   logic          OBSTRUCT = 1'b0;
   logic          FAULT_CLR = 1'b0;
   logic          UP_M;
   logic          DOWN_M;
   logic          FAULT;

   int checks = 0;
   int passes = 0;

   // Door model: motion +1 up, -1 down, 0 stopped; reversing pause and fault flags.
   int            m_motion = 0;
   int            m_last   = -1;
   bit            m_rev    = 1'b0;
   bit            m_flt    = 1'b0;
   int            m_cnt    = 0;
   logic [NR-1:0] m_prev   = '0;

   garage_door_ctrl_gen2 #(
      .NUM_REMOTES     (NR),
      .TRAVEL_TIMEOUT  (TMO),
      .REV_DWELL       (DWL),
      .AUTOCLOSE_CYCLES(ACL)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .Activate (Activate),
      .UP_MAX   (UP_MAX),
      .DOWN_MAX (DOWN_MAX),
      .OBSTRUCT (OBSTRUCT),
      .FAULT_CLR(FAULT_CLR),
      .UP_M     (UP_M),
      .DOWN_M   (DOWN_M),
      .FAULT    (FAULT)
   );

   always #50 CLK = ~CLK;

   task automatic model_step();
      bit pulse;
      bit changed;
      int was_motion;
      bit was_rev;
      bit was_flt;
      pulse  = |(Activate & ~m_prev);
      m_prev = Activate;
      if (RST) begin
         m_motion = 0; m_last = -1; m_rev = 0; m_flt = 0; m_cnt = 0; m_prev = '0;
         return;
      end
      was_motion = m_motion;
      was_rev    = m_rev;
      was_flt    = m_flt;
      if (m_flt) begin
         if (FAULT_CLR) m_flt = 0;
      end else if (UP_MAX && DOWN_MAX) begin
         m_flt = 1; m_motion = 0; m_rev = 0;
      end else if (m_rev) begin
         if (pulse) begin
            m_rev = 0; m_last = -1;
         end else if (m_cnt + 1 == DWL) begin
            m_rev = 0; m_motion = 1; m_last = 1;
         end
      end else if (m_motion == 1) begin
         if (UP_MAX || pulse) m_motion = 0;
         else if (m_cnt + 1 == TMO) begin m_motion = 0; m_flt = 1; end
      end else if (m_motion == -1) begin
         if (DOWN_MAX) m_motion = 0;
         else if (OBSTRUCT) begin m_motion = 0; m_rev = 1; end
         else if (pulse) m_motion = 0;
         else if (m_cnt + 1 == TMO) begin m_motion = 0; m_flt = 1; end
      end else if (pulse) begin
         if (DOWN_MAX) begin
            m_motion = 1; m_last = 1;
         end else if (UP_MAX) begin
            if (!OBSTRUCT) begin m_motion = -1; m_last = -1; end
         end else begin
            m_motion = -m_last; m_last = m_motion;
         end
      end
      changed = (m_motion != was_motion) || (m_rev != was_rev) || (m_flt != was_flt);
      m_cnt   = changed ? 0 : m_cnt + 1;
   endtask

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed {UP_M,DOWN_M,FAULT}=%b expected %b", tag, obs, exp);
   endtask

   task automatic expect_out(input string tag, input logic [2:0] exp);
      check(tag, {UP_M, DOWN_M, FAULT}, exp);
   endtask

   // One clock: inputs already driven, model advances with the DUT, compare after the edge.
   task automatic tick(input string tag);
      @(posedge CLK);
      model_step();
      #1;
      check(tag, {UP_M, DOWN_M, FAULT},
            {m_motion == 1 && !m_flt, m_motion == -1 && !m_flt, m_flt});
   endtask

   initial begin
      int r;

      // Reset
      RST = 1'b1;
      tick("model_reset");
      expect_out("reset", 3'b000);
      RST = 1'b0;

      // Close/open cycle
      DOWN_MAX = 1'b1; Activate = 2'b01;
      tick("model_open");
      expect_out("open_from_closed", 3'b100);
      DOWN_MAX = 1'b0;
      repeat (5) tick("model_hold");
      expect_out("held_no_retrigger", 3'b100);
      UP_MAX = 1'b1;
      tick("model_up_limit");
      expect_out("up_limit", 3'b000);

      // Mid-stop toggle
      Activate = 2'b00; tick("model_idle");
      Activate = 2'b10; tick("model_close");
      expect_out("open_to_down", 3'b010);
      UP_MAX = 1'b0;
      Activate = 2'b11; tick("model_stop");
      expect_out("mid_stop", 3'b000);
      Activate = 2'b00; tick("model_idle");
      Activate = 2'b01; tick("model_toggle");
      expect_out("toggle_up", 3'b100);
      Activate = 2'b00; tick("model_up");
      Activate = 2'b01; tick("model_stop_up");
      expect_out("stop_up", 3'b000);
      Activate = 2'b00; tick("model_idle");
      Activate = 2'b01; tick("model_toggle_dn");
      expect_out("toggle_down", 3'b010);
      Activate = 2'b00;

      // Obstruction reversal with dwell
      OBSTRUCT = 1'b1; tick("model_obstruct");
      expect_out("rev_wait_entry", 3'b000);
      OBSTRUCT = 1'b0;
      tick("model_dwell");
      tick("model_dwell");
      expect_out("dwell_motor_off", 3'b000);
      tick("model_reverse");
      expect_out("reversal_up", 3'b100);
      UP_MAX = 1'b1; tick("model_rev_limit");
      expect_out("reversal_up_limit", 3'b000);
      UP_MAX = 1'b0;

      // Travel timeout
      DOWN_MAX = 1'b1; Activate = 2'b01; tick("model_start_up");
      DOWN_MAX = 1'b0;
      for (int i = 0; i < TMO - 1; i++) tick("model_travel");
      expect_out("pre_timeout", 3'b100);
      tick("model_timeout");
      expect_out("timeout_fault", 3'b001);
      Activate = 2'b00; tick("model_fault");
      Activate = 2'b10; tick("model_fault_act");
      expect_out("fault_ignores_act", 3'b001);
      FAULT_CLR = 1'b1; tick("model_fault_clr");
      expect_out("fault_clear", 3'b000);
      FAULT_CLR = 1'b0;

      // Sensor conflict during downward travel
      Activate = 2'b00; tick("model_idle");
      UP_MAX = 1'b1; Activate = 2'b01; tick("model_down");
      expect_out("down_for_conflict", 3'b010);
      DOWN_MAX = 1'b1; tick("model_conflict");
      expect_out("conflict_fault", 3'b001);
      UP_MAX = 1'b0; DOWN_MAX = 1'b0; FAULT_CLR = 1'b1; tick("model_clr2");
      FAULT_CLR = 1'b0;

      // Reset mid-travel
      DOWN_MAX = 1'b1; Activate = 2'b00; tick("model_idle");
      Activate = 2'b10; tick("model_up3");
      expect_out("up_before_reset", 3'b100);
      DOWN_MAX = 1'b0; Activate = 2'b00; RST = 1'b1; tick("model_rst_mid");
      expect_out("reset_mid_travel", 3'b000);
      RST = 1'b0;

      // Open door left idle never moves on its own
      UP_MAX = 1'b1;
      repeat (100) tick("model_open_idle");
      expect_out("no_autoclose", 3'b000);
      UP_MAX = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         for (int b = 0; b < NR; b++)
            if ($urandom_range(0, 5) == 0) Activate[b] = ~Activate[b];
         r        = int'($urandom_range(0, 59));
         UP_MAX   = (r == 0) || (r >= 1 && r <= 5);
         DOWN_MAX = (r == 0) || (r >= 6 && r <= 10);
         OBSTRUCT = ($urandom_range(0, 7) == 0);
         FAULT_CLR = ($urandom_range(0, 9) == 0);
         RST      = ($urandom_range(0, 149) == 0);
         tick("random");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire
